// File: rtl/walk_mem_pkg.sv
`default_nettype none
// ============================================================================
// walk_mem_pkg : shared types and constants for the walk-engine memory responder
// Revision: 1.0
// ============================================================================
package walk_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INC   = 2'd2,
        OP_ADD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_CLR_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TBL_SEED      = 2'd0,
        TBL_NEIGHBOUR = 2'd1,
        TBL_SCORE     = 2'd2
    } table_e;

    localparam int RSP_DEPTH = 3;

    localparam int SEED_OFFSET      = 10;
    localparam int NEIGHBOUR_OFFSET = 30;
    localparam int SCORE_OFFSET     = 100;

    function automatic int unsigned table_base(input table_e t);
        case (t)
            TBL_SEED:      return SEED_OFFSET;
            TBL_NEIGHBOUR: return NEIGHBOUR_OFFSET;
            TBL_SCORE:     return SCORE_OFFSET;
            default:       return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/walk_rsp_fifo.sv
`default_nettype none
// ============================================================================
// walk_rsp_fifo : in-order response FIFO, RSP_DEPTH entries, async reset
// Revision: 1.0
// ============================================================================
module walk_rsp_fifo
    import walk_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_count,
    output logic                  o_empty
);
    localparam logic [1:0] c_last_ptr = 2'(RSP_DEPTH - 1);
    localparam logic [1:0] c_full_cnt = 2'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == c_last_ptr) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != c_full_cnt) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/walk_mem_responder.sv
`default_nettype none
// ============================================================================
// walk_mem_responder : BRAM responder for READ/WRITE/INC/ADD with same-address
// forwarding, in-order responses and a zeroing sweep. Revision: 1.0
// ============================================================================
module walk_mem_responder
    import walk_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_busy
);
    localparam int               IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] c_sweep_last = IDX_W'(DEPTH - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [IDX_W-1:0]      r_sweep_addr;
    logic [IDX_W-1:0]      w_sweep_nxt;

    logic                  r_s1_valid;
    op_e                   r_s1_op;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_in_range;
    logic                  r_s1_fwd;
    logic [DATA_WIDTH-1:0] r_s1_fwd_data;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] w_s1_old;
    logic [DATA_WIDTH-1:0] w_s1_result;
    logic                  w_s1_writes;
    logic                  w_fwd_hit;
    logic                  w_accept;
    logic                  w_req_in_range;
    logic                  w_fifo_empty;
    logic [1:0]            w_fifo_count;
    logic [2:0]            w_credit;

    generate
        if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_range_check
            assign w_req_in_range = (i_req_addr < ADDR_WIDTH'(DEPTH));
        end else begin : g_full_range
            assign w_req_in_range = 1'b1;
        end
    endgenerate

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_sweep_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_addr <= w_sweep_nxt;
        end
    end

    assign w_credit = {1'b0, w_fifo_count} + {2'b00, r_s1_valid};

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_addr;
        o_busy      = 1'b1;
        o_req_ready = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_sweep_addr == c_sweep_last) begin
                    w_state_nxt = ST_RUN;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep_addr + 1'b1;
                end
            end
            ST_RUN: begin
                o_busy      = 1'b0;
                // credit counts S1 too, so S1 always has a FIFO slot to land in
                o_req_ready = (w_credit < 3'(RSP_DEPTH));
                if (i_clear) begin
                    w_state_nxt = ST_CLR_WAIT;
                end
            end
            ST_CLR_WAIT: begin
                if (!r_s1_valid) begin
                    w_state_nxt = ST_INIT;
                    w_sweep_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_sweep_nxt = '0;
            end
        endcase
    end

    assign w_accept = i_req_valid && o_req_ready;

    // ---------------- array (no reset so it maps to block RAM) ----------------
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_sweep_addr] <= '0;
        end else if (w_s1_writes) begin
            r_mem[r_s1_addr[IDX_W-1:0]] <= w_s1_result;
        end
        if (w_accept && w_req_in_range) begin
            r_rd_data <= r_mem[i_req_addr[IDX_W-1:0]];
        end
    end

    // ---------------- S1: compute and write back ----------------
    assign w_s1_writes = r_s1_valid && r_s1_in_range && (r_s1_op != OP_READ);
    // the array read issued this edge misses the S1 write landing on the same edge
    assign w_fwd_hit   = w_s1_writes && (i_req_addr == r_s1_addr);

    always_comb begin
        w_s1_old = r_s1_fwd ? r_s1_fwd_data : r_rd_data;
        if (!r_s1_in_range) begin
            w_s1_old = '0;
        end
        w_s1_result = w_s1_old;
        case (r_s1_op)
            OP_READ:  w_s1_result = w_s1_old;
            OP_WRITE: w_s1_result = r_s1_data;
            OP_INC:   w_s1_result = w_s1_old + DATA_WIDTH'(1);
            OP_ADD:   w_s1_result = w_s1_old + r_s1_data;
            default:  w_s1_result = w_s1_old;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_op       <= OP_READ;
            r_s1_addr     <= '0;
            r_s1_data     <= '0;
            r_s1_in_range <= 1'b0;
            r_s1_fwd      <= 1'b0;
            r_s1_fwd_data <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op       <= op_e'(i_req_op);
                r_s1_addr     <= i_req_addr;
                r_s1_data     <= i_req_data;
                r_s1_in_range <= w_req_in_range;
                r_s1_fwd      <= w_fwd_hit;
                r_s1_fwd_data <= w_s1_result;
            end
        end
    end

    // ---------------- response FIFO ----------------
    walk_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_s1_valid),
        .i_push_data (w_s1_result),
        .i_pop       (i_rsp_ready),
        .o_head      (o_rsp_data),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty)
    );

    assign o_rsp_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_walk_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_walk_mem_responder : directed bench with a response scoreboard
// Revision: 1.0
// ============================================================================
module tb_walk_mem_responder;
    import walk_mem_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 8192;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          clear     = 1'b0;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b1;
    logic [1:0]    req_op    = 2'd0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_data  = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    int            rsp_n  = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mdl [DEPTH];

    walk_mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clear     (clear),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // reference behaviour applied in acceptance order
    task automatic model_apply(input op_e op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               output logic [DW-1:0] res);
        logic [DW-1:0] old;
        old = (int'(a) < DEPTH) ? mdl[a] : '0;
        case (op)
            OP_READ:  res = old;
            OP_WRITE: res = d;
            OP_INC:   res = old + 32'd1;
            default:  res = old + d;
        endcase
        if (op != OP_READ && int'(a) < DEPTH) mdl[a] = res;
    endtask

    // scoreboard: every response handshake is compared against the queue head
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: observed 0x%08h required no response", rsp_data);
            end
            if (exp_q.size() != 0) begin
                chk($sformatf("rsp%0d", rsp_n), rsp_data, exp_q.pop_front());
            end
            rsp_n++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // caller is at posedge+1; returns at posedge+1 after the accepting edge, valid still high
    task automatic do_req(input op_e op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        bit            acc = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                model_apply(op, a, d, e);
                exp_q.push_back(e);
            end
        end
        chk("req_accept", 32'(acc), 32'd1);
        sync();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        sync();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [AW-1:0] bp_addr [5];
    logic [DW-1:0] e_bp;
    int            idx;
    int            nbusy;

    initial begin
        model_clear();
        bp_addr = '{AW'(NEIGHBOUR_OFFSET), AW'(40), AW'(5), AW'(SCORE_OFFSET), AW'(SEED_OFFSET)};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        sync();
        rst = 1'b0;
        count_busy(nbusy);
        chk("init_len", 32'(nbusy), 32'd8192);
        chk("ready_after_init", 32'(req_ready), 32'd1);
        sync();

        do_req(OP_READ, AW'(table_base(TBL_SCORE)), '0);
        req_valid = 1'b0;
        drain();

        // write then read back-to-back
        do_req(OP_WRITE, AW'(table_base(TBL_NEIGHBOUR)), 32'h1234_5678);
        do_req(OP_READ, AW'(table_base(TBL_NEIGHBOUR)), '0);
        req_valid = 1'b0;
        drain();

        // back-to-back increments exercise forwarding
        do_req(OP_INC, AW'(40), '0);
        do_req(OP_INC, AW'(40), '0);
        do_req(OP_INC, AW'(40), '0);
        do_req(OP_READ, AW'(40), '0);
        req_valid = 1'b0;
        drain();

        // add wraps modulo 2^32
        do_req(OP_WRITE, AW'(5), 32'd2);
        do_req(OP_ADD, AW'(5), 32'hFFFF_FFFF);
        req_valid = 1'b0;
        drain();

        // backpressure: only three requests fit before a pop
        rsp_ready = 1'b0;
        idx       = 0;
        req_valid = 1'b1;
        req_op    = OP_READ;
        req_addr  = bp_addr[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                model_apply(OP_READ, bp_addr[idx], '0, e_bp);
                exp_q.push_back(e_bp);
                idx++;
            end
            sync();
            if (idx < 5) req_addr = bp_addr[idx];
            else req_valid = 1'b0;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                model_apply(OP_READ, bp_addr[idx], '0, e_bp);
                exp_q.push_back(e_bp);
                idx++;
            end
            sync();
            if (idx < 5) req_addr = bp_addr[idx];
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd5);
        drain();

        // clear with two responses queued
        rsp_ready = 1'b0;
        do_req(OP_READ, AW'(40), '0);
        do_req(OP_READ, AW'(NEIGHBOUR_OFFSET), '0);
        req_valid = 1'b0;
        sync();
        chk("clr_two_queued", 32'(rsp_valid), 32'd1);
        clear = 1'b1;
        sync();
        clear     = 1'b0;
        rsp_ready = 1'b1;
        model_clear();
        chk("clr_ready_low", 32'(req_ready), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        count_busy(nbusy);
        chk("clr_busy_len", 32'(nbusy), 32'd8193);
        chk("clr_drained", 32'(exp_q.size()), 32'd0);
        sync();
        do_req(OP_READ, AW'(40), '0);
        do_req(OP_WRITE, AW'(SEED_OFFSET), 32'hDEAD_BEEF);
        req_valid = 1'b0;
        drain();

        // reset in the middle of the sweep
        clear = 1'b1;
        sync();
        clear = 1'b0;
        repeat (4001) sync();
        chk("sweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_req_ready", 32'(req_ready), 32'd0);
        chk("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
        sync();
        rst = 1'b0;
        count_busy(nbusy);
        chk("rst2_init_len", 32'(nbusy), 32'd8192);
        sync();
        do_req(OP_READ, AW'(SEED_OFFSET), '0);
        do_req(OP_READ, AW'(40), '0);
        req_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
